// File: rtl/icache_responder.sv
// -----------------------------------------------------------------------------
// icache_responder
//
// Direct-mapped instruction cache front end: 64 sets of 16-byte lines, one
// valid bit per set. It accepts a fetch PC and answers with a 32-bit
// instruction word. A hit answers one cycle after acceptance. A miss first
// requests a line refill from memory and then answers in the cycle after the
// last refill beat.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   req_valid/req_addr  fetch request (req_addr[1:0] ignored)
//   icache_ready        request accepted when req_valid & icache_ready
//   icache_data(_valid) response word; held until resp_ack, zero when invalid
//   resp_ack            fetch stage 2 consumes the response this cycle
//   flush               cancels the outstanding request, blocks acceptance
//   mem_rd_req/addr     line refill request, 16-byte aligned address
//   mem_rd_ready        refill request accepted when mem_rd_req & mem_rd_ready
//   mem_rd_data(_valid) refill beats, four per line, word 0 first
//
// Handshake semantics (all interfaces): a transfer happens on a rising edge
// where the producer's valid/req is high and the consumer's ready/ack is high
// in the same cycle. A producer keeps valid and its payload stable until the
// transfer happens, unless flush or reset withdraws it.
// -----------------------------------------------------------------------------
module icache_responder (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  output logic        icache_ready,
  output logic [31:0] icache_data,
  output logic        icache_data_valid,
  input  logic        resp_ack,
  input  logic        flush,
  output logic        mem_rd_req,
  output logic [31:0] mem_rd_addr,
  input  logic        mem_rd_ready,
  input  logic [31:0] mem_rd_data,
  input  logic        mem_rd_data_valid
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_LOOKUP   = 2'd1,
    S_MISS_REQ = 2'd2,
    S_REFILL   = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:2] addr_q, addr_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        cancel_q, cancel_d;
  logic [63:0] valid_q, valid_d;

  // Tag and data storage carry no reset; the valid bits alone decide hits.
  logic [21:0] tag_q  [64];
  logic [31:0] line_q [64][4];

  logic        wr_word_en;
  logic        wr_tag_en;

  logic [5:0]  idx;
  logic [1:0]  off;
  logic [21:0] tag;
  logic        hit;
  logic [31:0] rd_word;

  // Byte offset within the word is not used by an instruction fetch.
  logic        unused_addr_bits;
  assign unused_addr_bits = ^req_addr[1:0];

  // Lookup works from the registered address only.
  assign idx     = addr_q[9:4];
  assign off     = addr_q[3:2];
  assign tag     = addr_q[31:10];
  assign hit     = valid_q[idx] & (tag_q[idx] == tag);
  assign rd_word = line_q[idx][off];

  always_comb begin
    state_d           = state_q;
    addr_d            = addr_q;
    cnt_d             = cnt_q;
    cancel_d          = cancel_q;
    valid_d           = valid_q;
    wr_word_en        = 1'b0;
    wr_tag_en         = 1'b0;
    icache_ready      = 1'b0;
    icache_data       = 32'h0;
    icache_data_valid = 1'b0;
    mem_rd_req        = 1'b0;
    mem_rd_addr       = 32'h0;

    case (state_q)
      S_IDLE: begin
        icache_ready = ~flush;
        if (req_valid && !flush) begin
          addr_d  = req_addr[31:2];
          state_d = S_LOOKUP;
        end
      end

      S_LOOKUP: begin
        if (flush) begin
          // Response is dropped in the flush cycle itself.
          state_d = S_IDLE;
        end else if (hit) begin
          icache_data_valid = 1'b1;
          icache_data       = rd_word;
          if (resp_ack) begin
            // Consuming the response frees the slot for a new request
            // in the same cycle, giving one response per cycle on hits.
            icache_ready = 1'b1;
            if (req_valid) begin
              addr_d  = req_addr[31:2];
              state_d = S_LOOKUP;
            end else begin
              state_d = S_IDLE;
            end
          end
        end else begin
          state_d = S_MISS_REQ;
        end
      end

      S_MISS_REQ: begin
        mem_rd_req  = 1'b1;
        mem_rd_addr = {addr_q[31:4], 4'b0000};
        if (mem_rd_ready) begin
          // Once memory has taken the request the line must be consumed,
          // so a coincident flush only marks the refill as cancelled.
          state_d  = S_REFILL;
          cnt_d    = 2'd0;
          cancel_d = flush;
        end else if (flush) begin
          state_d = S_IDLE;
        end
      end

      S_REFILL: begin
        cancel_d = cancel_q | flush;
        if (mem_rd_data_valid) begin
          wr_word_en = 1'b1;
          cnt_d      = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            wr_tag_en    = 1'b1;
            valid_d[idx] = 1'b1;
            cancel_d     = 1'b0;
            // A live refill revisits LOOKUP, which now hits.
            state_d      = (cancel_q | flush) ? S_IDLE : S_LOOKUP;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are forced quiet for the whole reset window, including the
    // first cycle before the state register has been cleared.
    if (rst) begin
      icache_ready      = 1'b0;
      icache_data       = 32'h0;
      icache_data_valid = 1'b0;
      mem_rd_req        = 1'b0;
      mem_rd_addr       = 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      cnt_q    <= 2'd0;
      cancel_q <= 1'b0;
      valid_q  <= 64'h0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      cancel_q <= cancel_d;
      valid_q  <= valid_d;
    end
  end

  // Storage writes are suppressed during reset so an aborted refill
  // leaves nothing behind; its set stays invalid in any case.
  always_ff @(posedge clk) begin
    if (!rst && wr_word_en) begin
      line_q[idx][cnt_q] <= mem_rd_data;
    end
    if (!rst && wr_tag_en) begin
      tag_q[idx] <= tag;
    end
  end

endmodule
